// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and word geometry.
package boot_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StHdr,
        StLoad,
        StChk,
        StRun,
        StErr
    } state_e;

endpackage

// File: rtl/byte_assembler.sv
// Collects accepted stream bytes into little-endian 32-bit words; word_valid pulses
// in the cycle the final byte of a word is accepted.
module byte_assembler
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    // Only the first three bytes need storage; the fourth is taken live.
    logic [23:0] sr_q, sr_d;

    always_comb begin
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        word_valid = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            sr_d       = {byte_data, sr_q[23:8]};
            cnt_d      = cnt_q + 2'd1;
            word_valid = (cnt_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    assign word = {byte_data, sr_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot-time image loader: writes a length-prefixed word stream into instruction memory and
// holds the CPU in reset until done. BOOT_LOADER_CHECKSUM_EN adds a trailing checksum word.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              DEPTH_WORDS   = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     reload,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic                     cpu_rst,
    output logic                     done,
    output logic                     error
);

    // One extra bit so a full-depth count N == DEPTH_WORDS is representable.
    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS) + 1;
    localparam logic [31:0] MaxWords = 32'(DEPTH_WORDS);

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [IdxW-1:0]          n_q, n_d;
    logic                     imem_we_q, imem_we_d;
    logic [ADDRESS_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0]    imem_wdata_q, imem_wdata_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0]              sum_q, sum_d;
`endif

    logic        accept;
    logic        word_valid;
    logic [31:0] word;

    assign accept = in_valid && in_ready;

    byte_assembler u_byte_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload),
        .byte_valid (accept),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        if (reload) begin
            state_d = StHdr;
            idx_d   = '0;
        end else begin
            case (state_q)
                StHdr: begin
                    if (word_valid) begin
                        n_d   = word[IdxW-1:0];
                        idx_d = '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        sum_d = word;
`endif
                        if (word > MaxWords) begin
                            state_d = StErr;
                        end else if (word == '0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                            state_d = StChk;
`else
                            state_d = StRun;
`endif
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (word_valid) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = BASE_ADDR + ADDRESS_WIDTH'({idx_q, 2'b00});
                        imem_wdata_d = DATA_WIDTH'(word);
                        idx_d        = idx_q + 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        sum_d        = sum_q + word;
                        if (idx_d == n_q) begin
                            state_d = StChk;
                        end
`endif
                    end
`ifndef BOOT_LOADER_CHECKSUM_EN
                    // Release the CPU only once the final write strobe has been issued.
                    if (imem_we_q && idx_q == n_q) begin
                        state_d = StRun;
                    end
`endif
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                StChk: begin
                    if (word_valid) begin
                        state_d = (word == sum_q) ? StRun : StErr;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StHdr;
            idx_q        <= '0;
            n_q          <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign in_ready   = (state_q == StHdr) || (state_q == StLoad) || (state_q == StChk);
    assign cpu_rst    = (state_q != StRun);
    assign done       = (state_q == StRun);
    assign error      = (state_q == StErr);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: stream-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_boot_loader;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit CHKEN = 1'b1;
`else
    localparam bit CHKEN = 1'b0;
`endif

    localparam int PH_HDR  = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CHK  = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_ERR  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        reload = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    boot_loader #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .DEPTH_WORDS   (DEPTH),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: gathers accepted bytes into words and applies the image rules.
    int          ph;
    int          nb;
    logic [31:0] wacc;
    logic [31:0] mw;
    logic [31:0] m_n;
    logic [31:0] m_sum;
    int          m_idx;
    logic        m_we;
    logic        m_fin;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        exp_ready;

    assign exp_ready = (ph == PH_HDR) || (ph == PH_LOAD) || (ph == PH_CHK);
    assign mw        = wacc | ({24'h0, in_data} << (8 * nb));

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph <= PH_HDR; nb <= 0; wacc <= '0; m_n <= '0; m_sum <= '0; m_idx <= 0;
            m_we <= 1'b0; m_fin <= 1'b0; m_addr <= BASE; m_wdata <= '0;
        end else begin
            m_we  <= 1'b0;
            m_fin <= 1'b0;
            if (reload) begin
                ph <= PH_HDR; nb <= 0; wacc <= '0; m_idx <= 0;
            end else begin
                if (m_fin) ph <= PH_RUN;
                if (in_valid && exp_ready) begin
                    if (nb < 3) begin
                        nb   <= nb + 1;
                        wacc <= mw;
                    end else begin
                        nb   <= 0;
                        wacc <= '0;
                        case (ph)
                            PH_HDR: begin
                                m_n   <= mw;
                                m_sum <= mw;
                                m_idx <= 0;
                                if (mw > DEPTH)    ph <= PH_ERR;
                                else if (mw == 0)  ph <= CHKEN ? PH_CHK : PH_RUN;
                                else               ph <= PH_LOAD;
                            end
                            PH_LOAD: begin
                                m_we    <= 1'b1;
                                m_addr  <= BASE + 32'(4 * m_idx);
                                m_wdata <= mw;
                                m_idx   <= m_idx + 1;
                                m_sum   <= m_sum + mw;
                                if (32'(m_idx + 1) == m_n) begin
                                    if (CHKEN) ph <= PH_CHK;
                                    else       m_fin <= 1'b1;
                                end
                            end
                            PH_CHK: ph <= (mw == m_sum) ? PH_RUN : PH_ERR;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          last_we_cyc = 0;
    int          done_cyc = 0;
    bit          done_seen = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check("in_ready",   in_ready,   exp_ready);
            check("imem_we",    imem_we,    m_we);
            check("imem_addr",  imem_addr,  m_addr);
            check("imem_wdata", imem_wdata, m_wdata);
            check("cpu_rst",    cpu_rst,    ph != PH_RUN);
            check("done",       done,       ph == PH_RUN);
            check("error",      error,      ph == PH_ERR);
            if (imem_we) begin
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_wdata);
                last_we_cyc = cyc;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    logic [31:0] img[$];

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        done_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; reload = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_logs();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic send_image(input logic [31:0] n, input int gap);
        logic [31:0] s;
        s = n;
        send_word(n, gap);
        foreach (img[i]) begin
            send_word(img[i], gap);
            s = s + img[i];
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_word(s, gap);
`endif
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nwrites"}, wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            check({tag, "_addr0"}, wr_addr[0], 32'h0);
            check({tag, "_data0"}, wr_data[0], 32'h0000_0013);
            check({tag, "_addr1"}, wr_addr[1], 32'h4);
            check({tag, "_data1"}, wr_data[1], 32'h0010_0093);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_cpu_rst"}, cpu_rst, 0);
`ifndef BOOT_LOADER_CHECKSUM_EN
        check({tag, "_done_lat"}, 32'(done_cyc - last_we_cyc), 1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, BASE);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst = 1'b1;
        clear_logs();
        @(negedge clk);

        // Two-word image, back-to-back bytes.
        img = '{32'h0000_0013, 32'h0010_0093};
        send_image(32'd2, 0);
        repeat (3) @(negedge clk);
        check_two_words("A");

        // Same image with in_valid toggling every other cycle.
        do_reset();
        send_image(32'd2, 1);
        repeat (3) @(negedge clk);
        check_two_words("B");

        // Oversized header.
        do_reset();
        send_word(32'h0000_0101, 0);
        repeat (3) @(negedge clk);
        check("C_error", error, 1);
        check("C_in_ready", in_ready, 0);
        check("C_cpu_rst", cpu_rst, 1);
        check("C_nwrites", wr_addr.size(), 0);

        // Reload out of ERR, empty image straight to RUN.
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("D_err_clr", error, 0);
        check("D_ready", in_ready, 1);
        img.delete();
        send_image(32'd0, 0);
        check("D_n0_done", done, 1);

        // Reload in RUN with a byte presented, then a dropped partial header.
        reload = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        reload = 1'b0; in_valid = 1'b0;
        check("D_rl_cpu_rst", cpu_rst, 1);
        check("D_rl_done", done, 0);
        clear_logs();
        send_byte(8'h55, 0);
        reload = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        reload = 1'b0; in_valid = 1'b0;
        img = '{32'hDEAD_BEEF};
        send_image(32'd1, 0);
        repeat (3) @(negedge clk);
        check("D_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() >= 1) begin
            check("D_addr0", wr_addr[0], 32'h0);
            check("D_data0", wr_data[0], 32'hDEAD_BEEF);
        end
        check("D_done", done, 1);

        // Asynchronous reset in the middle of a data word.
        do_reset();
        send_word(32'd1, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst = 1'b0;
        #1;
        check("E_in_ready", in_ready, 1);
        check("E_cpu_rst", cpu_rst, 1);
        check("E_done", done, 0);
        check("E_imem_we", imem_we, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_logs();
        @(negedge clk);
        img = '{32'hCAFE_F00D};
        send_image(32'd1, 0);
        repeat (3) @(negedge clk);
        check("E_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() >= 1) begin
            check("E_addr0", wr_addr[0], BASE);
            check("E_data0", wr_data[0], 32'hCAFE_F00D);
        end
        check("E_done_end", done, 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h10, 0);
        send_word(32'h11, 0);
        repeat (3) @(negedge clk);
        check("F_good_done", done, 1);
        check("F_good_error", error, 0);
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h10, 0);
        send_word(32'h12, 0);
        repeat (3) @(negedge clk);
        check("F_bad_error", error, 1);
        check("F_bad_done", done, 0);
        check("F_bad_cpu_rst", cpu_rst, 1);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
